// File: rtl/gpio_cfg_serializer.sv
// Serial configuration loader for a chain of GPIO pad control blocks.
// Shifts cfg_data out MSB-first, samples the chain return into rb_data, then strobes serial_load.
module gpio_cfg_serializer #(
   parameter int NUM_PADS      = 6,
   parameter int PAD_CTRL_BITS = 12,
   parameter int CLK_DIV       = 2
) (
   input  logic                                mclk,
   input  logic                                resetn,
   input  logic                                cfg_start,
   input  logic [NUM_PADS*PAD_CTRL_BITS-1:0]   cfg_data,
   output logic                                cfg_busy,
   output logic                                cfg_done,
   output logic                                serial_clock,
   output logic                                serial_data,
   output logic                                serial_load,
   input  logic                                serial_data_ret,
   output logic [NUM_PADS*PAD_CTRL_BITS-1:0]   rb_data
);

   // state    | meaning
   // IDLE     | waiting for cfg_start
   // SHIFT_LO | serial_clock low, serial_data presents shift-register MSB
   // SHIFT_HI | serial_clock high, return bit sampled in first cycle
   // LOAD_HI  | serial_load asserted
   // LOAD_LO  | serial_load released, settle before done
   // DONE     | one-cycle cfg_done pulse
   localparam int TOTAL = NUM_PADS * PAD_CTRL_BITS;
   localparam int DIVW  = $clog2(CLK_DIV + 1);
   localparam int BCW   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
   localparam logic [BCW-1:0]  BIT_LAST = BCW'(TOTAL - 1);

   typedef enum logic [2:0] {
      IDLE, SHIFT_LO, SHIFT_HI, LOAD_HI, LOAD_LO, DONE
   } state_t;

   state_t            r_state;
   logic [DIVW-1:0]   r_div;
   logic [BCW-1:0]    r_bitcnt;
   logic [TOTAL-1:0]  r_shreg;
   logic [TOTAL-1:0]  r_rb;
   logic              r_busy;
   logic              r_done;
   logic              r_sclk;
   logic              r_sdata;
   logic              r_sload;
   logic [TOTAL-1:0]  w_shifted;

   assign w_shifted = r_shreg << 1;

   always_ff @(posedge mclk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= IDLE;
         r_div    <= '0;
         r_bitcnt <= '0;
         r_shreg  <= '0;
         r_rb     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_sclk   <= 1'b0;
         r_sdata  <= 1'b0;
         r_sload  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cfg_start) begin
                  r_shreg  <= cfg_data;
                  r_bitcnt <= BIT_LAST;
                  r_div    <= DIV_LAST;
                  r_busy   <= 1'b1;
                  r_sdata  <= cfg_data[TOTAL-1];
                  r_state  <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (r_div == '0) begin
                  r_sclk  <= 1'b1;
                  r_div   <= DIV_LAST;
                  r_state <= SHIFT_HI;
               end else begin
                  r_div <= r_div - 1'b1;
               end
            end
            SHIFT_HI: begin
               // Sample the return bit once, at the end of the first high cycle.
               if (r_div == DIV_LAST)
                  r_rb <= {r_rb[TOTAL-2:0], serial_data_ret};
               if (r_div == '0) begin
                  r_sclk <= 1'b0;
                  r_div  <= DIV_LAST;
                  if (r_bitcnt == '0) begin
                     r_sdata <= 1'b0;
                     r_sload <= 1'b1;
                     r_state <= LOAD_HI;
                  end else begin
                     r_shreg  <= w_shifted;
                     r_sdata  <= w_shifted[TOTAL-1];
                     r_bitcnt <= r_bitcnt - 1'b1;
                     r_state  <= SHIFT_LO;
                  end
               end else begin
                  r_div <= r_div - 1'b1;
               end
            end
            LOAD_HI: begin
               if (r_div == '0) begin
                  r_sload <= 1'b0;
                  r_div   <= DIV_LAST;
                  r_state <= LOAD_LO;
               end else begin
                  r_div <= r_div - 1'b1;
               end
            end
            LOAD_LO: begin
               if (r_div == '0) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_div <= r_div - 1'b1;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cfg_busy     = r_busy;
   assign cfg_done     = r_done;
   assign serial_clock = r_sclk;
   assign serial_data  = r_sdata;
   assign serial_load  = r_sload;
   assign rb_data      = r_rb;

endmodule
